// File: rtl/uart_lt_pkg.sv
// Shared definitions for the UART echo-loop tester.
// Contents:
//   state_t     - tester FSM states (IDLE, SEND, WAIT_ECHO, CHECK, DONE)
//   rx_state_t  - receiver sequencer states
//   PRBS_SEED   - first byte of a PRBS run
//   PRBS_TAPS   - feedback taps of x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   bit_cnt()   - clocks per bit for a given clock and baud rate
//   prbs_next() - one step of the Fibonacci LFSR (shift left, feedback into bit 0)
package uart_lt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_CHECK     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] PRBS_SEED = 8'hA5;
    localparam logic [7:0] PRBS_TAPS = 8'hB8;

    function automatic int bit_cnt(input int clk_fre, input int baud);
        return clk_fre / baud;
    endfunction

    function automatic logic [7:0] prbs_next(input logic [7:0] s);
        return {s[6:0], ^(s & PRBS_TAPS)};
    endfunction

endpackage

// File: rtl/uart_lt_rx.sv
// UART receiver for the echo path: 2-FF synchroniser, falling-edge start detect,
// start-bit confirmation half a bit later, mid-bit sampling of 8 data bits (LSB
// first) and the stop bit.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   rx            - asynchronous serial input, idle high
//   rx_data       - last received byte
//   rx_valid      - 1-clk strobe, issued at the stop-bit sample point
//   rx_frame_err  - stop bit of the byte in rx_data was sampled low
module uart_lt_rx
    import uart_lt_pkg::*;
#(
    parameter int BIT_CNT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CW = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam logic [CW-1:0] HALF_PT = CW'(BIT_CNT / 2);
    localparam logic [CW-1:0] FULL_PT = CW'(BIT_CNT - 1);

    rx_state_t     state_r;
    rx_state_t     state_nxt_s;
    logic          rx_meta_r;
    logic          rx_sync_r;
    logic          rx_prev_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [7:0]    shift_r;
    logic          sample_s;
    logic          fall_s;

    assign fall_s = rx_prev_r & ~rx_sync_r;

    // Next-state and sample-point decode for the receive sequencer.
    always_comb begin
        state_nxt_s = state_r;
        sample_s    = 1'b0;
        case (state_r)
            RX_IDLE: begin
                if (fall_s) state_nxt_s = RX_START;
                else        state_nxt_s = RX_IDLE;
            end
            RX_START: begin
                if (cnt_r == HALF_PT) begin
                    sample_s = 1'b1;
                    // A start bit that is high again by mid-bit was noise.
                    if (rx_sync_r) state_nxt_s = RX_IDLE;
                    else           state_nxt_s = RX_DATA;
                end else begin
                    state_nxt_s = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_r == FULL_PT) begin
                    sample_s = 1'b1;
                    if (idx_r == 3'd7) state_nxt_s = RX_STOP;
                    else               state_nxt_s = RX_DATA;
                end else begin
                    state_nxt_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_r == FULL_PT) begin
                    sample_s    = 1'b1;
                    state_nxt_s = RX_IDLE;
                end else begin
                    state_nxt_s = RX_STOP;
                end
            end
            default: state_nxt_s = RX_IDLE;
        endcase
    end

    // Synchroniser, bit timing, shift register and byte strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RX_IDLE;
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            rx_prev_r    <= 1'b1;
            cnt_r        <= '0;
            idx_r        <= 3'd0;
            shift_r      <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            state_r   <= state_nxt_s;
            rx_valid  <= 1'b0;
            if (sample_s || state_r == RX_IDLE) cnt_r <= '0;
            else                                cnt_r <= cnt_r + CW'(1);
            if (state_r == RX_IDLE)                   idx_r <= 3'd0;
            else if (sample_s && state_r == RX_DATA)  idx_r <= idx_r + 3'd1;
            if (sample_s && state_r == RX_DATA) shift_r <= {rx_sync_r, shift_r[7:1]};
            if (sample_s && state_r == RX_STOP) begin
                rx_valid     <= 1'b1;
                rx_data      <= shift_r;
                rx_frame_err <= ~rx_sync_r;
            end
        end
    end

endmodule

// File: rtl/uart_loop_tester.sv
// Host-end initiator for a UART echo loop. Sends NUM_BYTES pattern bytes one at a
// time (stop-and-wait), waits for each echo, and counts mismatches, framing
// errors and timeouts.
// Configuration macro: UART_LT_PRBS_EN selects a PRBS8 pattern seeded with 8'hA5;
// without it the pattern is an incrementing byte starting at 8'h00.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - 1-clk pulse, starts a run from IDLE or DONE (ignored while busy)
//   rx        - echo input (asynchronous), tx - serial output, idle high
//   busy      - run in progress; done - run finished (held); pass - done with no errors
//   byte_cnt  - bytes completed in the current run
//   err_cnt   - mismatches + framing errors + timeouts, saturating
module uart_loop_tester
    import uart_lt_pkg::*;
#(
    parameter int BAUD         = 9600,
    parameter int CLK_FRE      = 50_000_000,
    parameter int NUM_BYTES    = 256,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] byte_cnt,
    output logic [15:0] err_cnt
);

    localparam int BIT_CNT = bit_cnt(CLK_FRE, BAUD);
    localparam int BW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam int TO_CNT  = TIMEOUT_BITS * BIT_CNT;
    localparam int TW      = (TO_CNT > 1) ? $clog2(TO_CNT) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CNT - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CNT - 1);
    localparam logic [15:0]   LAST_BYTE = 16'(NUM_BYTES);

`ifdef UART_LT_PRBS_EN
    localparam logic [7:0] PAT_SEED = PRBS_SEED;
    function automatic logic [7:0] pat_next(input logic [7:0] p);
        return prbs_next(p);
    endfunction
`else
    localparam logic [7:0] PAT_SEED = 8'h00;
    function automatic logic [7:0] pat_next(input logic [7:0] p);
        return p + 8'd1;
    endfunction
`endif

    state_t        state_r;
    state_t        state_nxt_s;
    logic          tx_r;
    logic          busy_r;
    logic          done_r;
    logic          pass_r;
    logic [15:0]   byte_cnt_r;
    logic [15:0]   err_cnt_r;
    logic [15:0]   err_cnt_nxt_s;
    logic [BW-1:0] bit_tmr_r;
    logic [3:0]    bit_idx_r;
    logic [8:0]    shift_r;
    logic [TW-1:0] to_tmr_r;
    logic [7:0]    pattern_r;
    logic [7:0]    rx_byte_r;
    logic          rx_ferr_r;
    logic          timeout_r;
    logic          bit_end_s;
    logic          chk_err_s;
    logic [7:0]    rx_data_s;
    logic          rx_valid_s;
    logic          rx_ferr_s;

    uart_lt_rx #(
        .BIT_CNT (BIT_CNT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data_s),
        .rx_valid     (rx_valid_s),
        .rx_frame_err (rx_ferr_s)
    );

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign byte_cnt = byte_cnt_r;
    assign err_cnt  = err_cnt_r;

    // Next-state decode plus the CHECK verdict and saturating error increment.
    always_comb begin
        state_nxt_s = state_r;
        bit_end_s   = (bit_tmr_r == BIT_LAST);
        chk_err_s   = timeout_r | rx_ferr_r | (rx_byte_r != pattern_r);
        if (chk_err_s && err_cnt_r != 16'hFFFF) err_cnt_nxt_s = err_cnt_r + 16'd1;
        else                                    err_cnt_nxt_s = err_cnt_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt_s = ST_SEND;
                else       state_nxt_s = state_r;
            end
            ST_SEND: begin
                if (bit_end_s && bit_idx_r == 4'd9) state_nxt_s = ST_WAIT_ECHO;
                else                                state_nxt_s = ST_SEND;
            end
            ST_WAIT_ECHO: begin
                // A byte landing on the expiry cycle still counts as an echo.
                if (rx_valid_s || to_tmr_r == TO_LAST) state_nxt_s = ST_CHECK;
                else                                   state_nxt_s = ST_WAIT_ECHO;
            end
            ST_CHECK: begin
                if (byte_cnt_r + 16'd1 == LAST_BYTE) state_nxt_s = ST_DONE;
                else                                 state_nxt_s = ST_SEND;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, transmitter, echo capture, pattern and run counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            byte_cnt_r <= 16'h0000;
            err_cnt_r  <= 16'h0000;
            bit_tmr_r  <= '0;
            bit_idx_r  <= 4'd0;
            shift_r    <= 9'h1FF;
            to_tmr_r   <= '0;
            pattern_r  <= 8'h00;
            rx_byte_r  <= 8'h00;
            rx_ferr_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        byte_cnt_r <= 16'h0000;
                        err_cnt_r  <= 16'h0000;
                        done_r     <= 1'b0;
                        pass_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        pattern_r  <= PAT_SEED;
                        shift_r    <= {1'b1, PAT_SEED};
                        tx_r       <= 1'b0;
                        bit_tmr_r  <= '0;
                        bit_idx_r  <= 4'd0;
                    end
                end
                ST_SEND: begin
                    // bit_idx 0 is the start bit, 1..8 data, 9 stop.
                    if (bit_end_s) begin
                        bit_tmr_r <= '0;
                        if (bit_idx_r == 4'd9) begin
                            tx_r     <= 1'b1;
                            to_tmr_r <= '0;
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b1, shift_r[8:1]};
                            bit_idx_r <= bit_idx_r + 4'd1;
                        end
                    end else begin
                        bit_tmr_r <= bit_tmr_r + BW'(1);
                    end
                end
                ST_WAIT_ECHO: begin
                    if (rx_valid_s) begin
                        rx_byte_r <= rx_data_s;
                        rx_ferr_r <= rx_ferr_s;
                        timeout_r <= 1'b0;
                    end else if (to_tmr_r == TO_LAST) begin
                        timeout_r <= 1'b1;
                    end else begin
                        to_tmr_r <= to_tmr_r + TW'(1);
                    end
                end
                ST_CHECK: begin
                    byte_cnt_r <= byte_cnt_r + 16'd1;
                    err_cnt_r  <= err_cnt_nxt_s;
                    if (state_nxt_s == ST_DONE) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        pass_r <= (err_cnt_nxt_s == 16'h0000);
                    end else begin
                        pattern_r <= pat_next(pattern_r);
                        shift_r   <= {1'b1, pat_next(pattern_r)};
                        tx_r      <= 1'b0;
                        bit_tmr_r <= '0;
                        bit_idx_r <= 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
